// File: rtl/fifo_tx_unpack_if.sv
// fifo_tx_unpack_if: write-side and byte-stream signals of the QSPI TX data path.
// slave is the data path's view, master is the driver/consumer view.
interface fifo_tx_unpack_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    // Control and FIFO write side
    logic          flush_i;
    logic          wr_en_i;
    logic [31:0]   wr_data_i;
    logic          full_o;
    logic          empty_o;
    logic [LW-1:0] level_o;
    logic          wr_ovf_o;

    // Transfer control and byte stream towards the shift engine
    logic          start_i;
    logic [15:0]   len_i;
    logic          byte_valid_o;
    logic [7:0]    byte_data_o;
    logic          byte_ready_i;
    logic          busy_o;
    logic          done_o;
    logic          stall_o;

    modport slave (
        input  flush_i, wr_en_i, wr_data_i, start_i, len_i, byte_ready_i,
        output full_o, empty_o, level_o, wr_ovf_o,
               byte_valid_o, byte_data_o, busy_o, done_o, stall_o
    );

    modport master (
        output flush_i, wr_en_i, wr_data_i, start_i, len_i, byte_ready_i,
        input  full_o, empty_o, level_o, wr_ovf_o,
               byte_valid_o, byte_data_o, busy_o, done_o, stall_o
    );
endinterface

// File: rtl/fifo_tx_unpack.sv
// fifo_tx_unpack: 32-bit word TX FIFO followed by a byte unpacker that feeds
// the QSPI shift engine over valid/ready. Transfer length is in bytes; unused
// bytes of the last word are dropped.
// Optional feature: define QSPI_TX_PREFETCH_EN to add a one-word hold register
// that removes the LOAD bubble at word boundaries.
// DEPTH must match the DEPTH of the connected fifo_tx_unpack_if.
module fifo_tx_unpack #(
    parameter int DEPTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    fifo_tx_unpack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          wr_ovf_q;

    logic [15:0]   rem_q;
    logic [1:0]    idx_q;
    logic [31:0]   shreg_q;

    logic          full, empty, wr_acc, accept;
    logic          pop_load, pop_any;
    logic [31:0]   head;
    logic [1:0]    byte_sel;

`ifdef QSPI_TX_PREFETCH_EN
    logic [31:0]   hold_q;
    logic          hold_vld_q;
    logic          pop_hold, ld_hold;
    logic [15:0]   word_bytes_left;
    assign word_bytes_left = 16'd4 - {14'd0, idx_q};
`endif

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem[rd_ptr_q];
    assign wr_acc  = bus.wr_en_i && !full && !bus.flush_i && !rst;
    assign accept  = (state_q == ST_SHIFT) && bus.byte_ready_i;
`ifdef QSPI_TX_PREFETCH_EN
    assign pop_any = pop_load || pop_hold;
`else
    assign pop_any = pop_load;
`endif

    // Word storage write port
    // NOTE: storage array has no reset; only pointers/count define its contents.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= bus.wr_data_i;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_ovf_q <= 1'b0;
        end else begin
            if (wr_acc)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_any) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(wr_acc) - CW'(pop_any);
            if (bus.wr_en_i && full) wr_ovf_q <= 1'b1;
        end
    end

    // Next-state and pop decisions of the unpacker
    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        state_d  = state_q;
        pop_load = 1'b0;
`ifdef QSPI_TX_PREFETCH_EN
        pop_hold = 1'b0;
        ld_hold  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) state_d = (bus.len_i == 16'd0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                if (!empty) begin
                    pop_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.byte_ready_i) begin
                    if (rem_q == 16'd1) begin
                        state_d = ST_DONE;
                    end else if (idx_q == 2'd3) begin
`ifdef QSPI_TX_PREFETCH_EN
                        if (hold_vld_q) ld_hold = 1'b1;
                        else            state_d = ST_LOAD;
`else
                        state_d = ST_LOAD;
`endif
                    end
                end
`ifdef QSPI_TX_PREFETCH_EN
                // Fetch ahead only if the transfer extends past the current word;
                // the word boundary itself is left to the LOAD fallback.
                if (!hold_vld_q && !empty && (rem_q > word_bytes_left) &&
                    !(bus.byte_ready_i && idx_q == 2'd3))
                    pop_hold = 1'b1;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, remaining count, byte index and shift register
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.start_i) rem_q <= bus.len_i;
            if (accept) begin
                rem_q <= rem_q - 16'd1;
                idx_q <= idx_q + 2'd1;
            end
            if (pop_load) begin
                shreg_q <= head;
                idx_q   <= '0;
            end
`ifdef QSPI_TX_PREFETCH_EN
            else if (ld_hold) begin
                shreg_q <= hold_q;
            end
`endif
        end
    end

`ifdef QSPI_TX_PREFETCH_EN
    // Prefetch hold register: filled during SHIFT, emptied into the shift register
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i || state_q == ST_DONE) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (pop_hold) begin
            hold_q     <= head;
            hold_vld_q <= 1'b1;
        end else if (ld_hold) begin
            hold_vld_q <= 1'b0;
        end
    end
`endif

    // Byte lane selection according to byte order
    always_comb begin
        byte_sel = MSB_FIRST ? (2'd3 - idx_q) : idx_q;
    end

    assign bus.byte_data_o  = shreg_q[{byte_sel, 3'b000} +: 8];
    assign bus.byte_valid_o = (state_q == ST_SHIFT);
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.done_o       = (state_q == ST_DONE);
    assign bus.stall_o      = (state_q == ST_LOAD) && empty;
    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.level_o      = count_q;
    assign bus.wr_ovf_o     = wr_ovf_q;
endmodule
